// File: rtl/nrisc_pkg.sv
// Shared constants for the nRISC multicycle core:
// opcodes, FSM state encoding, PC source and ULA operation codes.
package nrisc_pkg;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_ADDI = 4'b0010;
    localparam logic [3:0] OP_LW   = 4'b0011;
    localparam logic [3:0] OP_SW   = 4'b0100;
    localparam logic [3:0] OP_BEQ  = 4'b0101;
    localparam logic [3:0] OP_J    = 4'b0110;
    localparam logic [3:0] OP_HALT = 4'b1111;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6,
        S_ERROR  = 3'd7
    } state_t;

    localparam logic [1:0] PC_INC = 2'd0;
    localparam logic [1:0] PC_BR  = 2'd1;
    localparam logic [1:0] PC_JMP = 2'd2;

    localparam logic ULA_ADD = 1'b0;
    localparam logic ULA_SUB = 1'b1;

    function automatic logic op_valid(input logic [3:0] op);
        return (op <= OP_J) || (op == OP_HALT);
    endfunction

endpackage

// File: rtl/contador_espera.sv
// Memory wait counter: counts stalled cycles and flags the one
// cycle whose stall would exhaust the TIMEOUT budget.
module contador_espera #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int W = $clog2(TIMEOUT + 1);
    localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= cnt + 1'b1;
        end
    end

    // The TIMEOUT-th stalled cycle is the one that trips the error.
    assign expired = enable && (cnt == LAST);

endmodule

// File: rtl/controle_multiciclo.sv
// Multicycle control unit for the nRISC core: fetch/decode/exec/
// mem/writeback sequencing with memory wait timeout.
import nrisc_pkg::*;

module controle_multiciclo #(
    parameter int TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [3:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       op_ula,
    output logic       ula_src,
    output logic       reg_write,
    output logic       ir_write,
    output logic       pc_write,
    output logic       mem_read,
    output logic       mem_write,
    output logic       mem_to_reg,
    output logic [1:0] pc_src,
    output logic       halted,
    output logic       illegal,
    output logic [2:0] state
);

    state_t     st;
    state_t     nxt;
    logic [3:0] op_q;
    logic       clear;
    logic       enable;
    logic       expired;

    assign state  = st;
    assign enable = (st == S_FETCH || st == S_MEM) && !mem_ready;
    assign clear  = (nxt != st) && (nxt == S_FETCH || nxt == S_MEM);

    contador_espera #(
        .TIMEOUT(TIMEOUT)
    ) u_espera (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (clear),
        .enable (enable),
        .expired(expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st   <= S_IDLE;
            op_q <= '0;
        end else begin
            st <= nxt;
            if (st == S_DECODE) begin
                op_q <= opcode;
            end
        end
    end

    // Outputs are decoded from state plus inputs so that memory and
    // branch handshakes take effect in the same cycle.
    always_comb begin
        nxt        = st;
        op_ula     = ULA_ADD;
        ula_src    = 1'b0;
        reg_write  = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_to_reg = 1'b0;
        pc_src     = PC_INC;
        halted     = 1'b0;
        illegal    = 1'b0;
        unique case (st)
            S_IDLE: begin
                if (start) nxt = S_FETCH;
            end
            S_FETCH: begin
                mem_read = 1'b1;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    pc_src   = PC_INC;
                    nxt      = S_DECODE;
                end else if (expired) begin
                    nxt = S_ERROR;
                end
            end
            S_DECODE: begin
                unique case (1'b1)
                    opcode == OP_HALT: nxt = S_HALT;
                    opcode == OP_J: begin
                        pc_write = 1'b1;
                        pc_src   = PC_JMP;
                        nxt      = S_FETCH;
                    end
                    !op_valid(opcode): nxt = S_ERROR;
                    default: nxt = S_EXEC;
                endcase
            end
            S_EXEC: begin
                case (op_q)
                    OP_ADD: nxt = S_WB;
                    OP_SUB: begin
                        op_ula = ULA_SUB;
                        nxt    = S_WB;
                    end
                    OP_ADDI: begin
                        ula_src = 1'b1;
                        nxt     = S_WB;
                    end
                    OP_LW, OP_SW: begin
                        ula_src = 1'b1;
                        nxt     = S_MEM;
                    end
                    OP_BEQ: begin
                        op_ula = ULA_SUB;
                        if (zero) begin
                            pc_write = 1'b1;
                            pc_src   = PC_BR;
                        end
                        nxt = S_FETCH;
                    end
                    default: nxt = S_ERROR;
                endcase
            end
            S_MEM: begin
                mem_read  = (op_q == OP_LW);
                mem_write = (op_q == OP_SW);
                if (mem_ready) begin
                    nxt = (op_q == OP_LW) ? S_WB : S_FETCH;
                end else if (expired) begin
                    nxt = S_ERROR;
                end
            end
            S_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = (op_q == OP_LW);
                nxt        = S_FETCH;
            end
            S_HALT:  halted  = 1'b1;
            S_ERROR: illegal = 1'b1;
            default: nxt = S_ERROR;
        endcase
    end

endmodule

// File: tb/tb_controle_multiciclo.sv
// Self-checking bench for controle_multiciclo: directed scenarios plus
// a random instruction stream checked cycle by cycle against a model.
module tb_controle_multiciclo;

    localparam int TO = 15;

    typedef struct packed {
        logic [2:0] st;
        logic       op_ula;
        logic       ula_src;
        logic       reg_write;
        logic       ir_write;
        logic       pc_write;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic [1:0] pc_src;
        logic       halted;
        logic       illegal;
    } obs_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [3:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic       op_ula, ula_src, reg_write, ir_write, pc_write;
    logic       mem_read, mem_write, mem_to_reg, halted, illegal;
    logic [1:0] pc_src;
    logic [2:0] state;
    obs_t       o;
    int         total = 0;
    int         bad = 0;

    always #5 clk = ~clk;

    controle_multiciclo #(.TIMEOUT(TO)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .opcode    (opcode),
        .zero      (zero),
        .mem_ready (mem_ready),
        .op_ula    (op_ula),
        .ula_src   (ula_src),
        .reg_write (reg_write),
        .ir_write  (ir_write),
        .pc_write  (pc_write),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_to_reg(mem_to_reg),
        .pc_src    (pc_src),
        .halted    (halted),
        .illegal   (illegal),
        .state     (state)
    );

    assign o = {state, op_ula, ula_src, reg_write, ir_write, pc_write,
                mem_read, mem_write, mem_to_reg, pc_src, halted, illegal};

    function automatic obs_t base(input logic [2:0] s);
        obs_t e;
        e    = '0;
        e.st = s;
        return e;
    endfunction

    function automatic logic legal(input logic [3:0] op);
        return (op <= 4'd6) || (op == 4'd15);
    endfunction

    task automatic chk(input string tag, input obs_t e);
        #1;
        total++;
        assert (o === e) else begin
            bad++;
            $error("FAIL %s obs=%h exp=%h", tag, o, e);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        start     = 1'b0;
        mem_ready = 1'b0;
        zero      = 1'b0;
        opcode    = 4'd0;
        #3;
        chk("reset", base(3'd0));
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic begin_run();
        start = 1'b1;
        chk("idle_start", base(3'd0));
        tick();
        start = 1'b0;
    endtask

    // One instruction from FETCH: wf/wm are stalled cycles before
    // mem_ready; a value of TO or more means the access never completes.
    task automatic run_instr(input logic [3:0] op, input logic z,
                             input int wf, input int wm);
        obs_t e;
        logic ldst;
        ldst = (op == 4'd3) || (op == 4'd4);
        for (int i = 0; i < wf && i < TO; i++) begin
            mem_ready = 1'b0;
            start     = 1'($urandom);
            zero      = 1'($urandom);
            e = base(3'd1);
            e.mem_read = 1'b1;
            chk("fetch_wait", e);
            tick();
        end
        if (wf >= TO) begin
            e = base(3'd7);
            e.illegal = 1'b1;
            chk("fetch_timeout", e);
            return;
        end
        mem_ready = 1'b1;
        e = base(3'd1);
        e.mem_read = 1'b1;
        e.ir_write = 1'b1;
        e.pc_write = 1'b1;
        chk("fetch_done", e);
        tick();
        opcode    = op;
        mem_ready = 1'($urandom);
        e = base(3'd2);
        if (op == 4'd6) begin
            e.pc_write = 1'b1;
            e.pc_src   = 2'd2;
        end
        chk("decode", e);
        tick();
        opcode = 4'($urandom);
        if (op == 4'd6) return;
        if (op == 4'd15) begin
            e = base(3'd6);
            e.halted = 1'b1;
            chk("halt", e);
            return;
        end
        if (!legal(op)) begin
            e = base(3'd7);
            e.illegal = 1'b1;
            chk("illegal_op", e);
            return;
        end
        zero = z;
        e = base(3'd3);
        case (op)
            4'd1, 4'd5:       e.op_ula  = 1'b1;
            4'd2, 4'd3, 4'd4: e.ula_src = 1'b1;
            default: ;
        endcase
        if (op == 4'd5 && z) begin
            e.pc_write = 1'b1;
            e.pc_src   = 2'd1;
        end
        chk("exec", e);
        tick();
        if (op == 4'd5) return;
        if (ldst) begin
            e = base(3'd4);
            e.mem_read  = (op == 4'd3);
            e.mem_write = (op == 4'd4);
            for (int i = 0; i < wm && i < TO; i++) begin
                mem_ready = 1'b0;
                zero      = 1'($urandom);
                chk("mem_wait", e);
                tick();
            end
            if (wm >= TO) begin
                e = base(3'd7);
                e.illegal = 1'b1;
                chk("mem_timeout", e);
                return;
            end
            mem_ready = 1'b1;
            chk("mem_done", e);
            tick();
            if (op == 4'd4) return;
        end
        mem_ready = 1'($urandom);
        e = base(3'd5);
        e.reg_write  = 1'b1;
        e.mem_to_reg = (op == 4'd3);
        chk("wb", e);
        tick();
    endtask

    task automatic hold_terminal(input string tag, input obs_t e);
        for (int i = 0; i < 3; i++) begin
            start     = 1'($urandom);
            mem_ready = 1'($urandom);
            opcode    = 4'($urandom);
            chk(tag, e);
            tick();
        end
    endtask

    initial begin
        obs_t       e;
        logic [3:0] ops [7];
        int         wf;
        int         wm;
        ops = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6};

        do_reset();
        chk("idle_hold", base(3'd0));
        tick();
        chk("idle_hold2", base(3'd0));
        begin_run();
        run_instr(4'd0, 1'b0, 0, 0);
        run_instr(4'd5, 1'b1, 0, 0);
        run_instr(4'd5, 1'b0, 1, 0);
        run_instr(4'd3, 1'b0, 0, 3);
        run_instr(4'd4, 1'b0, 2, 1);
        run_instr(4'd1, 1'b0, 0, 0);
        run_instr(4'd2, 1'b0, 0, 0);
        run_instr(4'd6, 1'b0, 0, 0);
        run_instr(4'd0, 1'b0, TO - 1, 0);
        run_instr(4'd3, 1'b0, 0, TO - 1);

        for (int n = 0; n < 40; n++) begin
            wf = ($urandom_range(0, 5) == 0) ? TO - 1 : int'($urandom_range(0, 3));
            wm = ($urandom_range(0, 5) == 0) ? TO - 1 : int'($urandom_range(0, 3));
            run_instr(ops[$urandom_range(0, 6)], 1'($urandom), wf, wm);
        end

        run_instr(4'd15, 1'b0, 1, 0);
        e = base(3'd6);
        e.halted = 1'b1;
        hold_terminal("halt_hold", e);

        do_reset();
        begin_run();
        run_instr(4'd0, 1'b0, TO, 0);
        e = base(3'd7);
        e.illegal = 1'b1;
        hold_terminal("error_hold", e);

        do_reset();
        begin_run();
        run_instr(4'b1010, 1'b0, 0, 0);

        do_reset();
        begin_run();
        run_instr(4'd4, 1'b0, 0, TO);

        do_reset();
        begin_run();
        mem_ready = 1'b1;
        tick();
        opcode = 4'd4;
        tick();
        tick();
        mem_ready = 1'b0;
        e = base(3'd4);
        e.mem_write = 1'b1;
        chk("mem_before_rst", e);
        #1;
        rst_n = 1'b0;
        chk("async_rst", base(3'd0));
        tick();
        chk("rst_held", base(3'd0));
        rst_n = 1'b1;
        tick();
        chk("idle_after_rst", base(3'd0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
